// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm time-entry controller: field codes shown on
// edit_field, default mode code and field limits, and the edit FSM state type.
package alarm_pkg;

   localparam logic [2:0] SET_STATE_DEF = 3'b110;
   localparam int         HOUR_MAX_DEF  = 23;
   localparam int         MS_MAX        = 59;

   localparam logic [1:0] FLD_IDLE    = 2'd0;
   localparam logic [1:0] FLD_HOURS   = 2'd1;
   localparam logic [1:0] FLD_MINUTES = 2'd2;
   localparam logic [1:0] FLD_SECONDS = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOURS   = 2'd1,
      ST_MINUTES = 2'd2,
      ST_SECONDS = 2'd3
   } set_state_t;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button level. The pulse is high for the
// single cycle in which the level is high but was low on the previous clock,
// so a held button yields exactly one event.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic prev_q;

   // Remember the level seen at the previous clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= level;
   end

   assign pulse = level & ~prev_q;

endmodule

// File: rtl/alarm_set_ctrl.sv
// Multi-alarm time-entry controller. While the mode input equals SET_STATE the
// FSM walks hours -> minutes -> seconds on nxt events, editing a shadow copy of
// the selected alarm. Completing seconds commits the shadow to that alarm in one
// cycle; leaving the set mode early throws the shadow away.
//
// Handshake: there is no valid/ready pair here. Each button is a level whose
// rising edge is a one-shot request; commit is a one-cycle strobe coincident
// with the cycle on which a_* show the new alarm value.
module alarm_set_ctrl
   import alarm_pkg::*;
#(
   parameter int                 NUM_ALARMS = 2,
   parameter int                 STATE_W    = 3,
   parameter logic [STATE_W-1:0] SET_STATE  = STATE_W'(SET_STATE_DEF),
   parameter int                 HOUR_MAX   = HOUR_MAX_DEF,
   localparam int                SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STATE_W-1:0]      state,
   input  logic [SEL_W-1:0]        alarm_sel,
   input  logic                    nxt_btn,
   input  logic                    inc_btn,
   input  logic                    dec_btn,
   input  logic                    load_btn,
   input  logic [5:0]              in_time,
   output logic [5*NUM_ALARMS-1:0] a_hours,
   output logic [6*NUM_ALARMS-1:0] a_minutes,
   output logic [6*NUM_ALARMS-1:0] a_seconds,
   output logic [1:0]              edit_field,
   output logic [5:0]              edit_value,
   output logic                    commit
);

   localparam logic [5:0]       HMAX6   = 6'(HOUR_MAX);
   localparam logic [5:0]       MSMAX6  = 6'(MS_MAX);
   localparam logic [SEL_W-1:0] SEL_TOP = SEL_W'(NUM_ALARMS - 1);

   // Wrap/saturate edit of one field; load beats inc beats dec.
   function automatic logic [5:0] apply_op(input logic ld, input logic inc,
                                           input logic dec, input logic [5:0] v,
                                           input logic [5:0] mx, input logic [5:0] t);
      if (ld)       return (t > mx) ? mx : t;
      else if (inc) return (v == mx) ? 6'd0 : v + 6'd1;
      else if (dec) return (v == 6'd0) ? mx : v - 6'd1;
      else          return v;
   endfunction

   logic nxt_ev, inc_ev, dec_ev, load_ev;

   btn_edge u_nxt  (.clk(clk), .rst(rst), .level(nxt_btn),  .pulse(nxt_ev));
   btn_edge u_inc  (.clk(clk), .rst(rst), .level(inc_btn),  .pulse(inc_ev));
   btn_edge u_dec  (.clk(clk), .rst(rst), .level(dec_btn),  .pulse(dec_ev));
   btn_edge u_load (.clk(clk), .rst(rst), .level(load_btn), .pulse(load_ev));

   set_state_t       st_q, st_d;
   logic [SEL_W-1:0] sel_q, sel_d, sel_in;
   logic [4:0]       sh_h_q, sh_h_d;
   logic [5:0]       sh_m_q, sh_m_d;
   logic [5:0]       sh_s_q, sh_s_d;
   logic             commit_d;
   logic [1:0]       edit_field_d;
   logic [5:0]       edit_value_d;

   logic [4:0] hr_q [NUM_ALARMS];
   logic [5:0] mn_q [NUM_ALARMS];
   logic [5:0] sc_q [NUM_ALARMS];

   // A selector beyond the last alarm (non power-of-two count) targets the last one.
   assign sel_in = (int'(alarm_sel) > NUM_ALARMS - 1) ? SEL_TOP : alarm_sel;

   // Next state, shadow edits and the registered display/commit values.
   always_comb begin
      st_d         = st_q;
      sel_d        = sel_q;
      sh_h_d       = sh_h_q;
      sh_m_d       = sh_m_q;
      sh_s_d       = sh_s_q;
      commit_d     = 1'b0;
      edit_field_d = FLD_IDLE;
      edit_value_d = 6'd0;

      if (st_q == ST_IDLE) begin
         if (state == SET_STATE) begin
            st_d   = ST_HOURS;
            sel_d  = sel_in;
            sh_h_d = hr_q[sel_in];
            sh_m_d = mn_q[sel_in];
            sh_s_d = sc_q[sel_in];
         end
      end else if (state != SET_STATE) begin
         st_d = ST_IDLE;
      end else if (nxt_ev) begin
         case (st_q)
            ST_HOURS:   st_d = ST_MINUTES;
            ST_MINUTES: st_d = ST_SECONDS;
            default: begin
               st_d     = ST_IDLE;
               commit_d = 1'b1;
            end
         endcase
      end else begin
         case (st_q)
            ST_HOURS:   sh_h_d = 5'(apply_op(load_ev, inc_ev, dec_ev, {1'b0, sh_h_q}, HMAX6, in_time));
            ST_MINUTES: sh_m_d = apply_op(load_ev, inc_ev, dec_ev, sh_m_q, MSMAX6, in_time);
            default:    sh_s_d = apply_op(load_ev, inc_ev, dec_ev, sh_s_q, MSMAX6, in_time);
         endcase
      end

      case (st_d)
         ST_HOURS: begin
            edit_field_d = FLD_HOURS;
            edit_value_d = {1'b0, sh_h_d};
         end
         ST_MINUTES: begin
            edit_field_d = FLD_MINUTES;
            edit_value_d = sh_m_d;
         end
         ST_SECONDS: begin
            edit_field_d = FLD_SECONDS;
            edit_value_d = sh_s_d;
         end
         default: begin
            edit_field_d = FLD_IDLE;
            edit_value_d = 6'd0;
         end
      endcase
   end

   // FSM state, shadow fields and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q       <= ST_IDLE;
         sel_q      <= '0;
         sh_h_q     <= '0;
         sh_m_q     <= '0;
         sh_s_q     <= '0;
         edit_field <= FLD_IDLE;
         edit_value <= '0;
         commit     <= 1'b0;
      end else begin
         st_q       <= st_d;
         sel_q      <= sel_d;
         sh_h_q     <= sh_h_d;
         sh_m_q     <= sh_m_d;
         sh_s_q     <= sh_s_d;
         edit_field <= edit_field_d;
         edit_value <= edit_value_d;
         commit     <= commit_d;
      end
   end

   // Committed alarms; written on the same edge that raises commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            hr_q[i] <= '0;
            mn_q[i] <= '0;
            sc_q[i] <= '0;
         end
      end else if (commit_d) begin
         hr_q[sel_q] <= sh_h_q;
         mn_q[sel_q] <= sh_m_q;
         sc_q[sel_q] <= sh_s_q;
      end
   end

   for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_pack
      assign a_hours[5*g +: 5]   = hr_q[g];
      assign a_minutes[6*g +: 6] = mn_q[g];
      assign a_seconds[6*g +: 6] = sc_q[g];
   end

endmodule
